// File: rtl/mdu_alu.sv
// Multi-cycle EX-stage ALU. Single-cycle logic/arith/compare/shift ops, plus an
// iterative shift-add unsigned multiply and a restoring unsigned divide.
module mdu_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_2,
    output logic             zero_flag,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_ADD4  = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SLL   = 4'b1110;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;     // multiplicand or divisor
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier / dividend, becomes product LO / quotient
    logic [WIDTH-1:0] hi_q, hi_d;       // product HI accumulator / partial remainder
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_2_q, result_2_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem, div_quo;

    always_comb begin
        alu_res = '0;
        case (control)
            OP_AND:  alu_res = data1 & data2;
            OP_OR:   alu_res = data1 | data2;
            OP_ADD:  alu_res = data1 + data2;
            OP_ADD4: alu_res = data1 + WIDTH'(4);
            OP_SUB:  alu_res = data1 - data2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
            OP_NOR:  alu_res = ~(data1 | data2);
            OP_SLL:  alu_res = data2 << data1[CNT_W-2:0];
            default: alu_res = '0;
        endcase
    end

    // One multiply step: conditionally add, then shift {carry, hi, lo} right.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    // One restoring divide step; remainder < divisor keeps the shifted value within WIDTH+1 bits.
    always_comb begin
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opa_q};
        div_ge   = ~div_diff[WIDTH];
        div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_quo  = {lo_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        result_d   = result_q;
        result_2_d = result_2_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    zero_d = (data1 == data2);
                    case (control)
                        OP_MULTU: begin
                            opa_d   = data1;
                            lo_d    = data2;
                            hi_d    = '0;
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = MUL;
                        end
                        OP_DIVU: begin
                            if (data2 == '0) begin
                                result_d   = '1;
                                result_2_d = data1;
                                done_d     = 1'b1;
                            end else begin
                                opa_d   = data2;
                                lo_d    = data1;
                                hi_d    = '0;
                                cnt_d   = CNT_W'(WIDTH);
                                state_d = DIV;
                            end
                        end
                        default: begin
                            result_d   = alu_res;
                            result_2_d = alu_res;
                            done_d     = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                hi_d  = mul_hi;
                lo_d  = mul_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d   = mul_lo;
                    result_2_d = mul_hi;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            DIV: begin
                hi_d  = div_rem;
                lo_d  = div_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d   = div_quo;
                    result_2_d = div_rem;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opa_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            result_q   <= '0;
            result_2_q <= '0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            result_q   <= result_d;
            result_2_q <= result_2_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
        end
    end

    assign result    = result_q;
    assign result_2  = result_2_q;
    assign zero_flag = zero_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mdu_alu.md
# mdu_alu

Multi-cycle, parametrised successor to the single-cycle datapath ALU. Adds registered outputs, a start/busy/done handshake, an iterative unsigned multiply (full 2×WIDTH product) and an iterative unsigned divide (quotient and remainder). It sits in the EX stage and stalls the pipeline through `busy` while a multiply or divide is in flight. Logical, arithmetic, compare and shift operations still finish one cycle after `start`.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: width of the iteration counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launches the operation on `control`/`data1`/`data2`; sampled only when `busy`=0.
- `control`  in  4  opcode, listed under Operation.
- `data1`  in  WIDTH  operand A (shift amount for SLL).
- `data2`  in  WIDTH  operand B.
- `result`  out  WIDTH  primary result: ALU result, product LO, or quotient.
- `result_2`  out  WIDTH  secondary result: product HI or remainder; equals `result` for single-cycle ops.
- `zero_flag`  out  1  registered (data1 == data2), captured at accepted `start`.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse; `result`/`result_2` are valid from this cycle.

## Operation
- Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0011 data1+4; 0111 SLT (signed, result 1/0); 0101 SLTU (unsigned); 1100 NOR; 1110 SLL (data2 << data1[CNT_W-2:0]); 1000 MULTU; 1001 DIVU.
- Any other opcode: `result`=`result_2`=0 and `done` pulses; no error output.
- ADD/SUB/+4 wrap modulo 2^WIDTH; no overflow detection.
- FSM states: IDLE, MUL, DIV.
  - IDLE + `start` + single-cycle op: register the result, stay in IDLE, pulse `done` next cycle.
  - IDLE + `start` + MULTU: latch operands, clear the product accumulator, counter=WIDTH, go to MUL.
  - IDLE + `start` + DIVU with data2≠0: latch operands, clear the remainder, counter=WIDTH, go to DIV.
  - DIVU with data2=0: no iteration. `result` = all ones, `result_2` = data1, `done` next cycle, stay in IDLE.
- MUL: one shift-add step per cycle, LSB first. At counter==1, write product[WIDTH-1:0] to `result` and product[2W-1:W] to `result_2`, then return to IDLE.
- DIV: one restoring step per cycle, MSB first. At counter==1, write the quotient to `result` and the remainder to `result_2`, then return to IDLE.
- `result`, `result_2` and `zero_flag` hold their values until the next completion (or, for `zero_flag`, the next accepted `start`).
- `start` while `busy`=1 is ignored; operands and state are unaffected.
- `zero_flag` is updated on every accepted `start`, including multi-cycle ops.

## Timing
- Reset: state=IDLE, counter=0; `result`, `result_2`, `zero_flag`, `busy` and `done` are all 0 on the cycle after `reset` is sampled high.
- Reset mid-operation aborts the operation; no `done` is produced.
- `reset` has priority over `start` in the same cycle.
- Single-cycle op, `start` accepted at edge N: `done`=1 and the result is visible in cycle N+1; `busy` stays 0.
- MULTU/DIVU accepted at edge N: `busy`=1 for cycles N+1 through N+WIDTH. `done`=1 in cycle N+WIDTH+1, with `busy`=0 in that same cycle.
- Total multi-cycle latency is WIDTH+1 cycles.
- Back-to-back: `start` may be asserted in the `done` cycle and is accepted there; zero idle cycles between operations.
- `done` is never high for two consecutive cycles from one `start`; consecutive pulses only come from consecutive single-cycle ops.
- `busy` is purely state-derived (state≠IDLE); no combinational path from inputs to outputs.

## Test plan
- Reset, then single-cycle ops (WIDTH=32):
  - ADD 0xFFFFFFFF+1 -> `result`=0, `done` one cycle later, `zero_flag`=0.
  - SUB 5−5 -> `result`=0, `zero_flag`=1.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU with the same operands -> 0.
  - NOR 0 with 0 -> 0xFFFFFFFF.
  - SLL data1=4, data2=1 -> 0x10.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles `result`=0x00000001, `result_2`=0xFFFFFFFE; `busy` high exactly 32 cycles.
- DIVU 100 ÷ 7 -> `result`=14, `result_2`=2 at cycle N+33.
- DIVU 9 ÷ 0 -> `result`=0xFFFFFFFF, `result_2`=9, `done` at N+1, `busy` never asserted.
- `start`=ADD while MULTU is busy -> ignored; the product is still correct. A `start` issued in the `done` cycle -> accepted, result one cycle later.
- `reset` asserted at cycle 10 of a DIVU -> `busy`=0 and all outputs 0 next cycle; no `done` pulse. A new MULTU 3×4 afterwards -> `result`=12, `result_2`=0.
